// File: rtl/cc_miss_req_ctrl.sv
// ---------------------------------------------------------------------------
// cc_miss_req_ctrl
//
// Miss-request sequencer for the cache controller. It takes line-miss
// requests from the tag-compare stage and issues one 8-beat AXI WRAP read
// burst per miss on the memory AR channel. When the AR handshake happens it
// also pushes the full miss address into the miss-address FIFO. The
// data-fill path drains that FIFO on the first returning beat.
//
// Outstanding fills are counted as AR handshakes minus R-channel last
// beats. New misses are throttled once MAX_OUTSTANDING bursts are in flight.
//
// Optional build macro:
//    CC_MISS_REQ_MERGE_EN - drops a request that hits the same 64-byte line
//                           as the most recently issued burst while that
//                           burst (or any other) is still outstanding.
//
// Parameters:
//    MAX_OUTSTANDING - maximum bursts in flight (1..15)
//    CNT_W           - width of the outstanding counter
//
// Ports:
//    clk                    - clock, all state on rising edge
//    rst                    - asynchronous active-high reset
//    miss_req_valid_i       - miss request valid
//    miss_req_addr_i        - miss byte address
//    miss_req_ready_o       - request accepted when valid & ready
//    mem_arvalid_o          - AR valid
//    mem_araddr_o           - AR address, 8-byte aligned (critical word first)
//    mem_arlen_o            - AR length, constant 7 (8 beats)
//    mem_arsize_o           - AR size, constant 3 (8 bytes)
//    mem_arburst_o          - AR burst type, constant WRAP
//    mem_arready_i          - AR ready
//    mem_rvalid_i           - R-channel monitor: valid
//    mem_rready_i           - R-channel monitor: ready
//    mem_rlast_i            - R-channel monitor: last beat
//    miss_addr_fifo_full_i  - miss-address FIFO full
//    miss_addr_fifo_wren_o  - miss-address FIFO push strobe
//    miss_addr_fifo_wdata_o - full miss address pushed into the FIFO
//    outstanding_o          - bursts currently in flight
//    err_o                  - sticky: rlast seen while nothing was outstanding
// ---------------------------------------------------------------------------
module cc_miss_req_ctrl #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             miss_req_valid_i,
   input  logic [31:0]      miss_req_addr_i,
   output logic             miss_req_ready_o,
   output logic             mem_arvalid_o,
   output logic [31:0]      mem_araddr_o,
   output logic [3:0]       mem_arlen_o,
   output logic [2:0]       mem_arsize_o,
   output logic [1:0]       mem_arburst_o,
   input  logic             mem_arready_i,
   input  logic             mem_rvalid_i,
   input  logic             mem_rready_i,
   input  logic             mem_rlast_i,
   input  logic             miss_addr_fifo_full_i,
   output logic             miss_addr_fifo_wren_o,
   output logic [31:0]      miss_addr_fifo_wdata_o,
   output logic [CNT_W-1:0] outstanding_o,
   output logic             err_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [31:0]      req_addr_q;
   logic [31:0]      req_addr_d;
   logic [CNT_W-1:0] outstanding_q;
   logic             err_q;

   logic             ar_hs;
   logic             r_last_hs;
   logic             room_ok;
   logic             merge_hit;

   // Every burst is a full 64-byte line. The length, size and burst type
   // never change, so they are driven as constants, including in reset.
   assign mem_arlen_o   = 4'd7;
   assign mem_arsize_o  = 3'd3;
   assign mem_arburst_o = 2'b10;

   // The address is taken from the latched request, not from the live
   // input. That keeps it stable for the whole time AR is waiting for ready.
   assign mem_araddr_o           = {req_addr_q[31:3], 3'b000};
   assign miss_addr_fifo_wdata_o = req_addr_q;
   assign outstanding_o          = outstanding_q;
   assign err_o                  = err_q;

   // arvalid is decoded from the state register alone. There is no path
   // from arready into arvalid. Because the state resets asynchronously,
   // arvalid also drops the moment rst rises.
   assign mem_arvalid_o = (state_q == ISSUE);
   assign ar_hs         = mem_arvalid_o & mem_arready_i;
   assign r_last_hs     = mem_rvalid_i & mem_rready_i & mem_rlast_i;

   // A fresh burst needs two things. First, FIFO space now: this block is
   // the only writer, so space at acceptance is still there at the push.
   // Second, headroom below the in-flight limit.
   assign room_ok = !miss_addr_fifo_full_i &&
                    (outstanding_q < CNT_W'(MAX_OUTSTANDING));

`ifdef CC_MISS_REQ_MERGE_EN
   // Line address of the most recently issued burst. It only counts as
   // meaningful while something is still outstanding, so it needs no
   // separate valid bit.
   logic [25:0] last_line_q;

   // Capture the line of each burst as its AR handshake completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_line_q <= '0;
      end else if (ar_hs) begin
         last_line_q <= req_addr_q[31:6];
      end
   end

   // A hit on the in-flight line is absorbed without using any resource.
   // So it is accepted even at the outstanding limit or with the FIFO full.
   assign merge_hit = (outstanding_q != '0) &&
                      (miss_req_addr_i[31:6] == last_line_q);
`else
   assign merge_hit = 1'b0;
`endif

   // State and latched-request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
      end
   end

   // Next-state and handshake decode. ready is offered only in IDLE, so one
   // miss is accepted per two cycles at most. The FIFO push goes out in the
   // same cycle as the AR handshake, with the address that was latched.
   always_comb begin
      state_d               = state_q;
      req_addr_d            = req_addr_q;
      miss_req_ready_o      = 1'b0;
      miss_addr_fifo_wren_o = 1'b0;

      case (state_q)
         IDLE: begin
            miss_req_ready_o = merge_hit || room_ok;
            if (miss_req_valid_i && miss_req_ready_o && !merge_hit) begin
               req_addr_d = miss_req_addr_i;
               state_d    = ISSUE;
            end
         end

         ISSUE: begin
            if (mem_arready_i) begin
               miss_addr_fifo_wren_o = 1'b1;
               state_d               = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outstanding-burst counter.
   //  - An issue and a completion in the same cycle cancel out.
   //  - A last beat with nothing outstanding leaves the counter at zero and
   //    raises the sticky error flag instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         case ({ar_hs, r_last_hs})
            2'b10: begin
               outstanding_q <= outstanding_q + CNT_W'(1);
            end
            2'b01: begin
               if (outstanding_q != '0) begin
                  outstanding_q <= outstanding_q - CNT_W'(1);
               end else begin
                  err_q <= 1'b1;
               end
            end
            default: begin
               outstanding_q <= outstanding_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cc_miss_req_ctrl
//
// Self-checking bench for cc_miss_req_ctrl. The reference model keeps:
//  - a queue of accepted-but-not-yet-issued misses,
//  - an integer count of bursts in flight,
//  - a sticky error bit.
// Expected outputs are derived each cycle from those, following the
// behavioural rules of the block. Directed scenarios come first, then a
// randomized run.
// ---------------------------------------------------------------------------
module tb_cc_miss_req_ctrl;

   localparam int MAX_OUT = 4;
   localparam int CNT_W   = $clog2(MAX_OUT + 1);

   logic             clk;
   logic             rst;
   logic             miss_req_valid_i;
   logic [31:0]      miss_req_addr_i;
   logic             miss_req_ready_o;
   logic             mem_arvalid_o;
   logic [31:0]      mem_araddr_o;
   logic [3:0]       mem_arlen_o;
   logic [2:0]       mem_arsize_o;
   logic [1:0]       mem_arburst_o;
   logic             mem_arready_i;
   logic             mem_rvalid_i;
   logic             mem_rready_i;
   logic             mem_rlast_i;
   logic             miss_addr_fifo_full_i;
   logic             miss_addr_fifo_wren_o;
   logic [31:0]      miss_addr_fifo_wdata_o;
   logic [CNT_W-1:0] outstanding_o;
   logic             err_o;

   int compared;
   int mismatched;
   int pushes_seen;

   // Reference model state.
   logic [31:0] pend_q[$];
   logic [31:0] latched_m;
   logic [25:0] last_line_m;
   int          cnt_m;
   bit          err_m;

   cc_miss_req_ctrl #(.MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .miss_req_valid_i       (miss_req_valid_i),
      .miss_req_addr_i        (miss_req_addr_i),
      .miss_req_ready_o       (miss_req_ready_o),
      .mem_arvalid_o          (mem_arvalid_o),
      .mem_araddr_o           (mem_araddr_o),
      .mem_arlen_o            (mem_arlen_o),
      .mem_arsize_o           (mem_arsize_o),
      .mem_arburst_o          (mem_arburst_o),
      .mem_arready_i          (mem_arready_i),
      .mem_rvalid_i           (mem_rvalid_i),
      .mem_rready_i           (mem_rready_i),
      .mem_rlast_i            (mem_rlast_i),
      .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
      .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
      .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
      .outstanding_o          (outstanding_o),
      .err_o                  (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      pend_q.delete();
      latched_m   = 32'h0;
      last_line_m = 26'h0;
      cnt_m       = 0;
      err_m       = 1'b0;
   endtask

   // Drive one cycle of inputs at the falling edge. Check every output
   // against the model, advance the model, then let the rising edge happen.
   task automatic applyStimulus(input logic v, input logic [31:0] a,
                                input logic ar, input logic rv,
                                input logic rr, input logic rl,
                                input logic fl);
      bit          mh;
      bit          exp_ready;
      bit          exp_arvalid;
      bit          exp_wren;
      bit          inc;
      bit          dec;
      logic [31:0] cur;
      @(negedge clk);
      miss_req_valid_i      = v;
      miss_req_addr_i       = a;
      mem_arready_i         = ar;
      mem_rvalid_i          = rv;
      mem_rready_i          = rr;
      mem_rlast_i           = rl;
      miss_addr_fifo_full_i = fl;
      #1;
`ifdef CC_MISS_REQ_MERGE_EN
      mh = (cnt_m > 0) && (a[31:6] == last_line_m);
`else
      mh = 1'b0;
`endif
      exp_arvalid = (pend_q.size() != 0);
      exp_ready   = !exp_arvalid && (mh || (!fl && cnt_m < MAX_OUT));
      exp_wren    = exp_arvalid && ar;
      cur         = exp_arvalid ? pend_q[0] : latched_m;

      checkOutput("ready",    {31'h0, miss_req_ready_o},      {31'h0, exp_ready});
      checkOutput("arvalid",  {31'h0, mem_arvalid_o},         {31'h0, exp_arvalid});
      checkOutput("araddr",   mem_araddr_o,                   {cur[31:3], 3'b000});
      checkOutput("wren",     {31'h0, miss_addr_fifo_wren_o}, {31'h0, exp_wren});
      checkOutput("wdata",    miss_addr_fifo_wdata_o,         cur);
      checkOutput("outstand", 32'(outstanding_o),             32'(cnt_m));
      checkOutput("err",      {31'h0, err_o},                 {31'h0, err_m});
      if (miss_addr_fifo_wren_o) pushes_seen++;

      inc = exp_wren;
      dec = rv && rr && rl;
      if (inc && !dec) cnt_m++;
      else if (dec && !inc) begin
         if (cnt_m == 0) err_m = 1'b1;
         else            cnt_m--;
      end
      if (exp_wren) begin
         last_line_m = pend_q[0][31:6];
         void'(pend_q.pop_front());
      end
      if (v && exp_ready && !mh) begin
         pend_q.push_back(a);
         latched_m = a;
      end
      @(posedge clk);
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Shorthand for idle cycles and for cycles that only return an rlast.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
   endtask

   task automatic rlastCycle();
      applyStimulus(0, 32'h0, 1, 1, 1, 1, 0);
   endtask

   initial begin
      int          p0;
      int          exp_push;
      logic [31:0] ra;
      logic        rv;
      compared    = 0;
      mismatched  = 0;
      pushes_seen = 0;
      rst                   = 1'b1;
      miss_req_valid_i      = 1'b0;
      miss_req_addr_i       = 32'h0;
      mem_arready_i         = 1'b0;
      mem_rvalid_i          = 1'b0;
      mem_rready_i          = 1'b0;
      mem_rlast_i           = 1'b0;
      miss_addr_fifo_full_i = 1'b0;
      modelReset();
      applyReset();

      // Reset state, with the constant AR fields always driven.
      applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
      checkOutput("arlen",   32'(mem_arlen_o),   32'd7);
      checkOutput("arsize",  32'(mem_arsize_o),  32'd3);
      checkOutput("arburst", 32'(mem_arburst_o), 32'd2);

      // Single miss with arready already high: push one cycle after accept.
      p0 = pushes_seen;
      applyStimulus(1, 32'h0001_2348, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      checkOutput("single_push",  32'(pushes_seen - p0), 32'd1);
      checkOutput("single_wdata", miss_addr_fifo_wdata_o, 32'h0001_2348);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      checkOutput("single_cnt",   32'(outstanding_o), 32'd1);
      rlastCycle();
      idleCycles(1);
      checkOutput("single_drain", 32'(outstanding_o), 32'd0);

      // arready held low for 5 cycles: AR stays put, exactly one push.
      p0 = pushes_seen;
      applyStimulus(1, 32'h0000_5A5D, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      checkOutput("stall_push", 32'(pushes_seen - p0), 32'd1);
      rlastCycle();

      // Four misses to distinct lines saturate the limit; one rlast frees a slot.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 32'h0010_0000 + 32'(i) * 32'h100, 1, 0, 0, 0, 0);
         applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      end
      applyStimulus(1, 32'h0020_0000, 1, 0, 0, 0, 0);
      checkOutput("limit_ready", {31'h0, miss_req_ready_o}, 32'd0);
      rlastCycle();
      p0 = pushes_seen;
      applyStimulus(1, 32'h0020_0000, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      checkOutput("fifth_push", 32'(pushes_seen - p0), 32'd1);
      for (int i = 0; i < 4; i++) rlastCycle();
      idleCycles(1);

      // AR handshake and rlast in the same cycle at count 2.
      applyStimulus(1, 32'h0030_0000, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0031_0000, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0032_0000, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 1, 1, 1, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      checkOutput("same_cycle_cnt", 32'(outstanding_o), 32'd2);
      rlastCycle();
      rlastCycle();

      // rlast with nothing outstanding sets the sticky error.
      rlastCycle();
      idleCycles(3);
      checkOutput("err_sticky", {31'h0, err_o}, 32'd1);
      checkOutput("err_cnt",    32'(outstanding_o), 32'd0);

      // Reset asserted mid-ISSUE: arvalid drops without a clock edge.
      applyStimulus(1, 32'h0040_0008, 0, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
      @(negedge clk);
      miss_req_valid_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_arvalid", {31'h0, mem_arvalid_o}, 32'd0);
      checkOutput("rst_wren",    {31'h0, miss_addr_fifo_wren_o}, 32'd0);
      checkOutput("rst_araddr",  mem_araddr_o, 32'd0);
      checkOutput("rst_wdata",   miss_addr_fifo_wdata_o, 32'd0);
      checkOutput("rst_err",     {31'h0, err_o}, 32'd0);
      checkOutput("rst_cnt",     32'(outstanding_o), 32'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      idleCycles(1);

      // Two misses to the same line while the first is outstanding.
      p0 = pushes_seen;
      applyStimulus(1, 32'h0000_1040, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_1078, 1, 0, 0, 0, 0);
      idleCycles(2);
`ifdef CC_MISS_REQ_MERGE_EN
      exp_push = 1;
`else
      exp_push = 2;
`endif
      checkOutput("merge_push", 32'(pushes_seen - p0), 32'(exp_push));
      checkOutput("merge_cnt",  32'(outstanding_o),    32'(exp_push));
      for (int i = 0; i < exp_push; i++) rlastCycle();

      // Randomized traffic. Addresses come from a few lines so that merges
      // occur. rlast is only returned while the model has bursts in flight.
      for (int i = 0; i < 600; i++) begin
         ra = 32'h0000_1000 + (32'($urandom_range(0, 3)) << 6) +
              32'($urandom_range(0, 63));
         rv = (cnt_m > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         applyStimulus(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                       rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
